// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - pipeline hazard detection, operand forwarding selects and stall/flush counters
module hazard_fwd_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_wr,
    input  logic              id_is_load,
    input  logic              ex_br_taken,
    input  logic              mem_stall,
    output logic [1:0]        FselA,
    output logic [1:0]        FselB,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              uses_rs1;
        logic              uses_rs2;
        logic [REG_AW-1:0] rd;
        logic              reg_wr;
        logic              is_load;
    } ex_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ex_t               ex_q, ex_d;
    logic              mem_valid_q, mem_reg_wr_q, mem_is_load_q;
    logic [REG_AW-1:0] mem_rd_q;
    logic              wb_valid_q, wb_reg_wr_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic mem_wr_ok, wb_wr_ok;
    logic mem_hit_rs1, mem_hit_rs2, wb_hit_rs1, wb_hit_rs2;
    logic load_use;

    // A load sitting in MEM has no data yet, so it is never a forwarding source.
    assign mem_wr_ok   = mem_valid_q && mem_reg_wr_q && !mem_is_load_q && (mem_rd_q != '0);
    assign wb_wr_ok    = wb_valid_q && wb_reg_wr_q && (wb_rd_q != '0);
    assign mem_hit_rs1 = mem_wr_ok && (mem_rd_q == ex_q.rs1);
    assign mem_hit_rs2 = mem_wr_ok && (mem_rd_q == ex_q.rs2);
    assign wb_hit_rs1  = wb_wr_ok && (wb_rd_q == ex_q.rs1);
    assign wb_hit_rs2  = wb_wr_ok && (wb_rd_q == ex_q.rs2);

    assign load_use = id_valid && ex_q.valid && ex_q.is_load && (ex_q.rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_q.rd)));

    always_comb begin
        FselA = 2'b00;
        FselB = 2'b00;
        if (ex_q.uses_rs1 && mem_hit_rs1)      FselA = 2'b01;
        else if (ex_q.uses_rs1 && wb_hit_rs1)  FselA = 2'b10;
        if (ex_q.uses_rs2 && mem_hit_rs2)      FselB = 2'b01;
        else if (ex_q.uses_rs2 && wb_hit_rs2)  FselB = 2'b10;
    end

    // Controls are forced low while reset is held, whatever the inputs do.
    always_comb begin
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
            end else if (ex_br_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
        end
    end

    always_comb begin
        ex_d        = ex_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!mem_stall) begin
            if (ex_br_taken) begin
                ex_d = '0;
                if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
            end else if (load_use) begin
                ex_d = '0;
                if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
            end else begin
                ex_d.valid    = id_valid;
                ex_d.rs1      = id_rs1;
                ex_d.rs2      = id_rs2;
                ex_d.uses_rs1 = id_uses_rs1;
                ex_d.uses_rs2 = id_uses_rs2;
                ex_d.rd       = id_rd;
                ex_d.reg_wr   = id_reg_wr;
                ex_d.is_load  = id_is_load;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q          <= '0;
            mem_valid_q   <= 1'b0;
            mem_reg_wr_q  <= 1'b0;
            mem_is_load_q <= 1'b0;
            mem_rd_q      <= '0;
            wb_valid_q    <= 1'b0;
            wb_reg_wr_q   <= 1'b0;
            wb_rd_q       <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            if (!mem_stall) begin
                mem_valid_q   <= ex_q.valid;
                mem_reg_wr_q  <= ex_q.reg_wr;
                mem_is_load_q <= ex_q.is_load;
                mem_rd_q      <= ex_q.rd;
                wb_valid_q    <= mem_valid_q;
                wb_reg_wr_q   <= mem_reg_wr_q;
                wb_rd_q       <= mem_rd_q;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - directed self-checking bench for hazard_fwd_ctrl
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst, rst_s;
    logic       id_valid, id_uses_rs1, id_uses_rs2, id_reg_wr, id_is_load;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_br_taken, mem_stall;

    logic [1:0]  FselA, FselB;
    logic        stall_pc, stall_if_id, flush_if_id, flush_id_ex;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  ctl;

    logic [1:0] s_fsela, s_fselb, s_stall_cnt, s_flush_cnt;
    logic       s_stall_pc, s_stall_if_id, s_flush_if_id, s_flush_id_ex;
    logic [3:0] s_ctl;

    int checks = 0;
    int errors = 0;

    assign ctl   = {stall_pc, stall_if_id, flush_if_id, flush_id_ex};
    assign s_ctl = {s_stall_pc, s_stall_if_id, s_flush_if_id, s_flush_id_ex};

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
        .mem_stall(mem_stall), .FselA(FselA), .FselB(FselB), .stall_pc(stall_pc),
        .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst_s), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
        .mem_stall(mem_stall), .FselA(s_fsela), .FselB(s_fselb), .stall_pc(s_stall_pc),
        .stall_if_id(s_stall_if_id), .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task tick;
        @(posedge clk);
        #1;
    endtask

    task issue(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u1,
               input logic u2, input logic [4:0] rd, input logic wr, input logic ld);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rd = rd; id_reg_wr = wr; id_is_load = ld;
        #1;
    endtask

    task drain;
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick;
    endtask

    task test_reset;
        if ({ctl, FselA, FselB} !== 8'h00) begin errors++; $display("FAIL rst_held_outs got %h exp 00", {ctl, FselA, FselB}); end checks++;
        if ({stall_cnt, flush_cnt} !== 32'h0) begin errors++; $display("FAIL rst_held_cnts got %h exp 0", {stall_cnt, flush_cnt}); end checks++;
        ex_br_taken = 1'b1; mem_stall = 1'b1; #1;
        if (ctl !== 4'b0000) begin errors++; $display("FAIL rst_gates_ctl got %b exp 0000", ctl); end checks++;
        ex_br_taken = 1'b0; mem_stall = 1'b0;
        tick;
        rst = 1'b0;
        issue(1, 1, 2, 1, 1, 5, 1, 0);
        if ({ctl, FselA, FselB} !== 8'h00) begin errors++; $display("FAIL post_rst_first got %h exp 00", {ctl, FselA, FselB}); end checks++;
        tick;
        issue(1, 5, 6, 1, 1, 8, 1, 0);
        tick;
        if (FselA !== 2'b01) begin errors++; $display("FAIL dirty_fsela got %b exp 01", FselA); end checks++;
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        ex_br_taken = 1'b1;
        tick;
        if (flush_cnt !== 16'd1) begin errors++; $display("FAIL dirty_flush_cnt got %0d exp 1", flush_cnt); end checks++;
        #2 rst = 1'b1;
        #1;
        if ({ctl, FselA, FselB} !== 8'h00) begin errors++; $display("FAIL async_rst_outs got %h exp 00", {ctl, FselA, FselB}); end checks++;
        if (flush_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_cnt got %0d exp 0", flush_cnt); end checks++;
        tick;
        if (flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_hold_edge_cnt got %0d exp 0", flush_cnt); end checks++;
        ex_br_taken = 1'b0;
        rst = 1'b0;
        #1;
        if ({ctl, FselA, FselB} !== 8'h00) begin errors++; $display("FAIL rst_release got %h exp 00", {ctl, FselA, FselB}); end checks++;
    endtask

    task test_alu_chain;
        issue(1, 1, 2, 1, 1, 5, 1, 0); tick;
        issue(1, 5, 6, 1, 1, 8, 1, 0); tick;
        if (FselA !== 2'b01) begin errors++; $display("FAIL alu_mem_fwd FselA got %b exp 01", FselA); end checks++;
        if (FselB !== 2'b00) begin errors++; $display("FAIL alu_mem_fwd FselB got %b exp 00", FselB); end checks++;
        drain;
        issue(1, 1, 2, 1, 1, 6, 1, 0); tick;
        issue(0, 0, 0, 0, 0, 0, 0, 0); tick;
        issue(1, 6, 7, 1, 1, 9, 1, 0); tick;
        if (FselA !== 2'b10) begin errors++; $display("FAIL alu_wb_fwd FselA got %b exp 10", FselA); end checks++;
        drain;
        issue(1, 1, 2, 1, 1, 0, 1, 0); tick;
        issue(1, 0, 0, 1, 1, 9, 1, 0); tick;
        if ({FselA, FselB} !== 4'b0000) begin errors++; $display("FAIL alu_x0 Fsel got %b exp 0000", {FselA, FselB}); end checks++;
        drain;
    endtask

    task test_double_write;
        issue(1, 1, 2, 1, 1, 7, 1, 0); tick;
        issue(1, 3, 4, 1, 1, 7, 1, 0); tick;
        issue(1, 9, 7, 1, 1, 11, 1, 0); tick;
        if (FselB !== 2'b01) begin errors++; $display("FAIL dbl_write FselB got %b exp 01", FselB); end checks++;
        if (FselA !== 2'b00) begin errors++; $display("FAIL dbl_write FselA got %b exp 00", FselA); end checks++;
        drain;
    endtask

    task test_load_use;
        issue(1, 2, 0, 1, 0, 3, 1, 1); tick;
        issue(1, 3, 4, 1, 1, 10, 1, 0);
        if (ctl !== 4'b1101) begin errors++; $display("FAIL lu_ctl got %b exp 1101", ctl); end checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL lu_cnt_before got %0d exp 0", stall_cnt); end checks++;
        tick;
        if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_after got %0d exp 1", stall_cnt); end checks++;
        if (ctl !== 4'b0000) begin errors++; $display("FAIL lu_one_cycle got %b exp 0000", ctl); end checks++;
        tick;
        if ({FselA, FselB} !== 4'b1000) begin errors++; $display("FAIL lu_wb_fwd got %b exp 1000", {FselA, FselB}); end checks++;
        drain;
        issue(1, 2, 0, 1, 0, 3, 1, 1); tick;
        issue(0, 3, 0, 1, 0, 0, 0, 0);
        if (ctl !== 4'b0000) begin errors++; $display("FAIL lu_id_invalid got %b exp 0000", ctl); end checks++;
        tick;
        if (FselA !== 2'b00) begin errors++; $display("FAIL load_in_mem_nofwd got %b exp 00", FselA); end checks++;
        drain;
    endtask

    task test_branch_load;
        issue(1, 2, 0, 1, 0, 3, 1, 1); tick;
        issue(1, 3, 4, 1, 1, 10, 1, 0);
        ex_br_taken = 1'b1; #1;
        if (ctl !== 4'b0011) begin errors++; $display("FAIL br_lu_ctl got %b exp 0011", ctl); end checks++;
        tick;
        ex_br_taken = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        if (flush_cnt !== 16'd1) begin errors++; $display("FAIL br_flush_cnt got %0d exp 1", flush_cnt); end checks++;
        if (stall_cnt !== 16'd1) begin errors++; $display("FAIL br_stall_cnt got %0d exp 1", stall_cnt); end checks++;
        drain;
    endtask

    task test_mem_stall;
        issue(1, 1, 2, 1, 1, 5, 1, 0); tick;
        issue(1, 5, 5, 1, 1, 8, 1, 0); tick;
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        mem_stall = 1'b1; ex_br_taken = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            if (ctl !== 4'b1100) begin errors++; $display("FAIL mstall_ctl[%0d] got %b exp 1100", i, ctl); end checks++;
            if ({FselA, FselB} !== 4'b0101) begin errors++; $display("FAIL mstall_fsel[%0d] got %b exp 0101", i, {FselA, FselB}); end checks++;
            if (flush_cnt !== 16'd1) begin errors++; $display("FAIL mstall_cnt[%0d] got %0d exp 1", i, flush_cnt); end checks++;
            tick;
        end
        mem_stall = 1'b0; #1;
        if (ctl !== 4'b0011) begin errors++; $display("FAIL mstall_release got %b exp 0011", ctl); end checks++;
        if ({FselA, FselB} !== 4'b0101) begin errors++; $display("FAIL mstall_release_fsel got %b exp 0101", {FselA, FselB}); end checks++;
        tick;
        ex_br_taken = 1'b0; #1;
        if (flush_cnt !== 16'd2) begin errors++; $display("FAIL mstall_flush_once got %0d exp 2", flush_cnt); end checks++;
        if (ctl !== 4'b0000) begin errors++; $display("FAIL mstall_after got %b exp 0000", ctl); end checks++;
        drain;
    endtask

    task test_saturation;
        logic [1:0] exp_cnt;
        if (s_stall_cnt !== 2'd0) begin errors++; $display("FAIL sat_reset got %0d exp 0", s_stall_cnt); end checks++;
        rst_s = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_cnt = (k < 3) ? 2'(k + 1) : 2'd3;
            issue(1, 2, 0, 1, 0, 3, 1, 1); tick;
            issue(1, 3, 3, 1, 1, 10, 1, 0);
            if (s_ctl !== 4'b1101) begin errors++; $display("FAIL sat_lu_ctl[%0d] got %b exp 1101", k, s_ctl); end checks++;
            tick;
            if (s_ctl !== 4'b0000) begin errors++; $display("FAIL sat_one_cycle[%0d] got %b exp 0000", k, s_ctl); end checks++;
            if (s_stall_cnt !== exp_cnt) begin errors++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", k, s_stall_cnt, exp_cnt); end checks++;
            drain;
        end
        if (stall_cnt !== 16'd5) begin errors++; $display("FAIL wide_cnt got %0d exp 5", stall_cnt); end checks++;
    endtask

    initial begin
        rst = 1'b1; rst_s = 1'b1;
        ex_br_taken = 1'b0; mem_stall = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        test_reset;
        test_alu_chain;
        test_double_write;
        test_load_use;
        test_branch_load;
        test_mem_stall;
        test_saturation;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
